// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_if_pkg
//  Purpose  : Shared definitions for the CPU-to-backing-memory line interface:
//             default width constants, the line-master state encoding, the
//             full-line vector type and a counter-width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

   localparam int MEM_ADDR_BITS = 28;
   localparam int MEM_DATA_BITS = 128;
   localparam int MEM_TAG_BITS  = 5;
   localparam int MEM_BEATS     = 4;
   localparam int MEM_LINE_BITS = MEM_BEATS * MEM_DATA_BITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } mlm_state_t;

   typedef logic [MEM_LINE_BITS-1:0] mem_line_t;

   // Beat index width; a single-beat line still needs a 1-bit counter.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/beat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : beat_counter
//  Purpose  : Wrapping beat index for a BEATS-long burst. Returns to 0 after
//             the last beat is counted.
//  Ports    : clk, reset  - clock, synchronous active-high reset
//             i_clr       - force the count to 0
//             i_inc       - count one beat
//             o_cnt       - current beat index
//             o_last      - current index is the final beat (BEATS-1)
//  Revision : 1.0 - initial release
// ============================================================================
module beat_counter
   import mem_if_pkg::*;
#(
   parameter int BEATS = MEM_BEATS,
   localparam int CNT_W = cnt_width(BEATS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_line_master.sv
`default_nettype none
// ============================================================================
//  Module   : mem_line_master
//  Purpose  : Initiator side of the cache-to-memory interface. Takes one full
//             cache-line read or write and serialises it as a request, then
//             BEATS write-data beats or BEATS read-response beats. One
//             transaction outstanding at a time.
//  Config   : `MEM_TAG_CHECK_EN - when defined, read beats whose tag differs
//             from TAG_ID are dropped and raise the sticky tag_err flag.
//             When undefined, mem_resp_tag is ignored and tag_err is 0.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             line_req_*            - cache-side line request (valid/ready)
//             line_resp_valid/data  - completion pulse, assembled read line
//             mem_req_*             - memory request channel (valid/ready)
//             mem_req_data_*        - memory write-data channel (valid/ready)
//             mem_resp_*            - memory response channel (no ready)
//             tag_err               - sticky response-tag mismatch flag
//  Revision : 1.0 - initial release
// ============================================================================
module mem_line_master
   import mem_if_pkg::*;
#(
   parameter int ADDR_BITS = MEM_ADDR_BITS,
   parameter int DATA_BITS = MEM_DATA_BITS,
   parameter int TAG_BITS  = MEM_TAG_BITS,
   parameter int BEATS     = MEM_BEATS,
   parameter int TAG_ID    = 0,
   localparam int LINE_BITS = BEATS * DATA_BITS
) (
   input  logic                     clk,
   input  logic                     reset,
   // cache side
   input  logic                     line_req_valid,
   output logic                     line_req_ready,
   input  logic                     line_req_rw,
   input  logic [ADDR_BITS-1:0]     line_req_addr,
   input  logic [LINE_BITS-1:0]     line_req_data,
   input  logic [LINE_BITS/8-1:0]   line_req_mask,
   output logic                     line_resp_valid,
   output logic [LINE_BITS-1:0]     line_resp_data,
   // memory request channel
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_rw,
   output logic [ADDR_BITS-1:0]     mem_req_addr,
   output logic [TAG_BITS-1:0]      mem_req_tag,
   // memory write-data channel
   output logic                     mem_req_data_valid,
   input  logic                     mem_req_data_ready,
   output logic [DATA_BITS-1:0]     mem_req_data_bits,
   output logic [DATA_BITS/8-1:0]   mem_req_data_mask,
   // memory response channel
   input  logic                     mem_resp_valid,
   input  logic [TAG_BITS-1:0]      mem_resp_tag,
   input  logic [DATA_BITS-1:0]     mem_resp_data,
   // status
   output logic                     tag_err
);

   localparam int CNT_W = cnt_width(BEATS);
   localparam int MASK_BITS = DATA_BITS / 8;

   mlm_state_t r_state, w_state_nxt;

   logic                   r_rw;
   logic [ADDR_BITS-1:0]   r_addr;
   logic [LINE_BITS-1:0]   r_data;
   logic [LINE_BITS/8-1:0] r_mask;
   logic [LINE_BITS-1:0]   r_asm;
   logic [LINE_BITS-1:0]   r_line;
   logic                   r_resp_valid;

   logic [LINE_BITS-1:0]   w_asm_nxt;
   logic [CNT_W-1:0]       w_cnt;
   logic                   w_last;
   logic                   w_cnt_inc;
   logic                   w_cnt_clr;
   logic                   w_accept;
   logic                   w_tag_ok;
   logic                   w_beat_ok;
   logic                   w_done;

   logic [DATA_BITS-1:0]   w_wbeat [BEATS];
   logic [MASK_BITS-1:0]   w_wmask [BEATS];

   // Split the latched line and mask into per-beat views.
   generate
      for (genvar k = 0; k < BEATS; k++) begin : g_beat_split
         assign w_wbeat[k] = r_data[k*DATA_BITS +: DATA_BITS];
         assign w_wmask[k] = r_mask[k*MASK_BITS +: MASK_BITS];
      end
   endgenerate

   // Ready only in IDLE, never during reset, and not in the completion
   // cycle (state is already IDLE then, but no back-to-back accept).
   assign line_req_ready = (r_state == ST_IDLE) & ~r_resp_valid & ~reset;
   assign w_accept       = line_req_valid & line_req_ready;

   // ----------------------------------------------------------- tag check
`ifdef MEM_TAG_CHECK_EN
   logic r_tag_err;

   assign w_tag_ok = (mem_resp_tag == TAG_BITS'(TAG_ID));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_err <= 1'b0;
      end else if ((r_state == ST_RDATA) && mem_resp_valid && !w_tag_ok) begin
         r_tag_err <= 1'b1;
      end
   end

   assign tag_err = r_tag_err;
`else
   logic w_unused_tag;

   assign w_tag_ok     = 1'b1;
   assign w_unused_tag = ^mem_resp_tag;
   assign tag_err      = 1'b0;
`endif

   assign w_beat_ok = mem_resp_valid & w_tag_ok;

   // ---------------------------------------------------------- beat count
   beat_counter #(
      .BEATS (BEATS)
   ) u_beat_counter (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (w_cnt_clr),
      .i_inc  (w_cnt_inc),
      .o_cnt  (w_cnt),
      .o_last (w_last)
   );

   // Final counted beat of either burst direction.
   assign w_done = w_cnt_inc & w_last;

   // ----------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_cnt_clr          = 1'b0;
      w_cnt_inc          = 1'b0;
      mem_req_valid      = 1'b0;
      mem_req_rw         = 1'b0;
      mem_req_addr       = '0;
      mem_req_tag        = '0;
      mem_req_data_valid = 1'b0;
      mem_req_data_bits  = '0;
      mem_req_data_mask  = '0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_REQ;
            end
         end

         ST_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = r_rw;
            mem_req_addr  = r_addr;
            mem_req_tag   = TAG_BITS'(TAG_ID);
            if (mem_req_ready) begin
               w_state_nxt = r_rw ? ST_WDATA : ST_RDATA;
            end
         end

         ST_WDATA: begin
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = w_wbeat[w_cnt];
            mem_req_data_mask  = w_wmask[w_cnt];
            if (mem_req_data_ready) begin
               w_cnt_inc = 1'b1;
               if (w_last) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         ST_RDATA: begin
            if (w_beat_ok) begin
               w_cnt_inc = 1'b1;
               if (w_last) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------- request latching
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rw   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_mask <= '0;
      end else if (w_accept) begin
         r_rw   <= line_req_rw;
         r_addr <= line_req_addr;
         r_data <= line_req_data;
         r_mask <= line_req_mask;
      end
   end

   // ------------------------------------------------------ read assembly
   // Beats collect in a separate buffer so the visible read line holds its
   // previous value until the new line is complete.
   always_comb begin
      w_asm_nxt = r_asm;
      for (int k = 0; k < BEATS; k++) begin
         if (w_cnt == CNT_W'(k)) begin
            w_asm_nxt[k*DATA_BITS +: DATA_BITS] = mem_resp_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_asm        <= '0;
         r_line       <= '0;
         r_resp_valid <= 1'b0;
      end else begin
         r_resp_valid <= w_done;
         if ((r_state == ST_RDATA) && w_beat_ok) begin
            r_asm <= w_asm_nxt;
            if (w_last) begin
               r_line <= w_asm_nxt;
            end
         end
      end
   end

   assign line_resp_valid = r_resp_valid;
   assign line_resp_data  = r_line;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_line_master
//  Purpose  : Directed self-checking bench for mem_line_master with default
//             parameters. The tag-mismatch scenario is compiled in only when
//             `MEM_TAG_CHECK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_line_master;
   import mem_if_pkg::*;

   localparam int AW = MEM_ADDR_BITS;
   localparam int DW = MEM_DATA_BITS;
   localparam int TW = MEM_TAG_BITS;
   localparam int LW = MEM_LINE_BITS;

   logic              clk;
   logic              reset;
   logic              line_req_valid;
   logic              line_req_ready;
   logic              line_req_rw;
   logic [AW-1:0]     line_req_addr;
   logic [LW-1:0]     line_req_data;
   logic [LW/8-1:0]   line_req_mask;
   logic              line_resp_valid;
   logic [LW-1:0]     line_resp_data;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_rw;
   logic [AW-1:0]     mem_req_addr;
   logic [TW-1:0]     mem_req_tag;
   logic              mem_req_data_valid;
   logic              mem_req_data_ready;
   logic [DW-1:0]     mem_req_data_bits;
   logic [DW/8-1:0]   mem_req_data_mask;
   logic              mem_resp_valid;
   logic [TW-1:0]     mem_resp_tag;
   logic [DW-1:0]     mem_resp_data;
   logic              tag_err;

   mem_line_master u_dut (
      .clk                (clk),
      .reset              (reset),
      .line_req_valid     (line_req_valid),
      .line_req_ready     (line_req_ready),
      .line_req_rw        (line_req_rw),
      .line_req_addr      (line_req_addr),
      .line_req_data      (line_req_data),
      .line_req_mask      (line_req_mask),
      .line_resp_valid    (line_resp_valid),
      .line_resp_data     (line_resp_data),
      .mem_req_valid      (mem_req_valid),
      .mem_req_ready      (mem_req_ready),
      .mem_req_rw         (mem_req_rw),
      .mem_req_addr       (mem_req_addr),
      .mem_req_tag        (mem_req_tag),
      .mem_req_data_valid (mem_req_data_valid),
      .mem_req_data_ready (mem_req_data_ready),
      .mem_req_data_bits  (mem_req_data_bits),
      .mem_req_data_mask  (mem_req_data_mask),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_tag       (mem_resp_tag),
      .mem_resp_data      (mem_resp_data),
      .tag_err            (tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling and driving happen 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a line request in the current cycle; returns in the cycle after
   // the accept edge (REQ state).
   task automatic do_accept(input logic rw, input logic [AW-1:0] addr,
                            input logic [LW-1:0] data);
      line_req_valid = 1'b1;
      line_req_rw    = rw;
      line_req_addr  = addr;
      line_req_data  = data;
      line_req_mask  = '1;
      chk("accept_ready", LW'(line_req_ready), LW'(1'b1));
      step();
      line_req_valid = 1'b0;
   endtask

   task automatic drive_beat(input logic [DW-1:0] data, input logic [TW-1:0] tag);
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      mem_resp_tag   = tag;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_tag   = '0;
   endtask

   logic [DW-1:0] beats [4];
   logic [LW-1:0] exp_line;
   logic [LW-1:0] prev_line;
   logic [LW-1:0] wline;
   int            lat;
   int            bi;
   int            gaps [4];
   logic          pat  [6];

   initial begin
      reset              = 1'b1;
      line_req_valid     = 1'b0;
      line_req_rw        = 1'b0;
      line_req_addr      = '0;
      line_req_data      = '0;
      line_req_mask      = '0;
      mem_req_ready      = 1'b0;
      mem_req_data_ready = 1'b0;
      mem_resp_valid     = 1'b0;
      mem_resp_tag       = '0;
      mem_resp_data      = '0;

      // ------------------------------------------------------------ reset
      step(); step();
      chk("rst_ready",      LW'(line_req_ready),     '0);
      chk("rst_req_valid",  LW'(mem_req_valid),      '0);
      chk("rst_resp_valid", LW'(line_resp_valid),    '0);
      chk("rst_resp_data",  line_resp_data,          '0);
      chk("rst_data_valid", LW'(mem_req_data_valid), '0);
      chk("rst_tag_err",    LW'(tag_err),            '0);
      reset = 1'b0;
      step();
      chk("post_rst_ready", LW'(line_req_ready), LW'(1'b1));

      // ------------------------------------------- read, zero stall
      for (int k = 0; k < 4; k++) beats[k] = {16{8'(8'h11 * k)}};
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      do_accept(1'b0, AW'(28'h0000123), '0);
      lat = 1;
      chk("rd_req_valid", LW'(mem_req_valid), LW'(1'b1));
      chk("rd_req_addr",  LW'(mem_req_addr),  LW'(28'h0000123));
      chk("rd_req_rw",    LW'(mem_req_rw),    '0);
      chk("rd_req_tag",   LW'(mem_req_tag),   '0);
      chk("rd_busy",      LW'(line_req_ready), '0);
      mem_req_ready = 1'b1;
      step(); lat++;
      mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("rd_no_early", LW'(line_resp_valid), '0);
         drive_beat(beats[k], '0);
         lat++;
      end
      chk("rd_latency",    LW'(lat),             LW'(6));
      chk("rd_resp_valid", LW'(line_resp_valid), LW'(1'b1));
      chk("rd_resp_data",  line_resp_data,       exp_line);
      chk("rd_cpl_ready",  LW'(line_req_ready),  '0);
      step();
      chk("rd_pulse_end",  LW'(line_resp_valid), '0);
      chk("rd_ready_back", LW'(line_req_ready),  LW'(1'b1));
      chk("rd_data_held",  line_resp_data,       exp_line);
      prev_line = exp_line;

      // ---------------------------------------------- write with stalls
      for (int k = 0; k < 4; k++) wline[k*DW +: DW] = {4{32'hD000_0000 + 32'(k)}};
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      do_accept(1'b1, AW'(28'h0000456), wline);
      chk("wr_req_rw",      LW'(mem_req_rw),         LW'(1'b1));
      chk("wr_req_addr",    LW'(mem_req_addr),       LW'(28'h0000456));
      chk("wr_no_early_wd", LW'(mem_req_data_valid), '0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      bi = 0;
      for (int i = 0; i < 6; i++) begin
         chk("wr_wd_valid", LW'(mem_req_data_valid), LW'(1'b1));
         chk("wr_wd_bits",  LW'(mem_req_data_bits),  LW'({4{32'hD000_0000 + 32'(bi)}}));
         chk("wr_wd_mask",  LW'(mem_req_data_mask),  LW'({16{1'b1}}));
         chk("wr_no_early", LW'(line_resp_valid),    '0);
         mem_req_data_ready = pat[i];
         step();
         if (pat[i]) bi++;
      end
      mem_req_data_ready = 1'b0;
      chk("wr_resp_valid", LW'(line_resp_valid),    LW'(1'b1));
      chk("wr_wd_done",    LW'(mem_req_data_valid), '0);
      chk("wr_rdata_kept", line_resp_data,          prev_line);
      step();
      chk("wr_pulse_end",  LW'(line_resp_valid),    '0);
      chk("wr_ready_back", LW'(line_req_ready),     LW'(1'b1));

      // ------------------------ request backpressure then gapped read
      for (int k = 0; k < 4; k++) beats[k] = {8{16'(16'hA000 + 16'(k))}};
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      gaps = '{2, 0, 3, 1};
      do_accept(1'b0, AW'(28'h0ABCDEF), '0);
      for (int i = 0; i < 10; i++) begin
         chk("bp_req_valid",  LW'(mem_req_valid),      LW'(1'b1));
         chk("bp_req_addr",   LW'(mem_req_addr),       LW'(28'h0ABCDEF));
         chk("bp_req_rw",     LW'(mem_req_rw),         '0);
         chk("bp_busy",       LW'(line_req_ready),     '0);
         chk("bp_no_wdata",   LW'(mem_req_data_valid), '0);
         step();
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("gap_req_done", LW'(mem_req_valid), '0);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gaps[k]; g++) begin
            chk("gap_no_early", LW'(line_resp_valid), '0);
            chk("gap_held",     line_resp_data,       prev_line);
            step();
         end
         chk("gap_no_early", LW'(line_resp_valid), '0);
         drive_beat(beats[k], '0);
      end
      chk("gap_resp_valid", LW'(line_resp_valid), LW'(1'b1));
      chk("gap_resp_data",  line_resp_data,       exp_line);
      step();
      chk("gap_pulse_end",  LW'(line_resp_valid), '0);

      // --------------------------------------------------- reset mid-read
      for (int k = 0; k < 4; k++) beats[k] = {4{32'h5EED_0000 + 32'(k)}};
      do_accept(1'b0, AW'(28'h0000777), '0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      drive_beat(beats[0], '0);
      drive_beat(beats[1], '0);
      reset = 1'b1;
      step();
      chk("mrst_req_valid",  LW'(mem_req_valid),      '0);
      chk("mrst_ready",      LW'(line_req_ready),     '0);
      chk("mrst_resp_valid", LW'(line_resp_valid),    '0);
      chk("mrst_resp_data",  line_resp_data,          '0);
      chk("mrst_data_valid", LW'(mem_req_data_valid), '0);
      reset = 1'b0;
      drive_beat(beats[2], '0);
      drive_beat(beats[3], '0);
      chk("late_resp_valid", LW'(line_resp_valid), '0);
      chk("late_resp_data",  line_resp_data,       '0);
      chk("late_ready",      LW'(line_req_ready),  LW'(1'b1));
      for (int k = 0; k < 4; k++) beats[k] = {4{32'hC0DE_0000 + 32'(k)}};
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      do_accept(1'b0, AW'(28'h0000888), '0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) drive_beat(beats[k], '0);
      chk("rerd_resp_valid", LW'(line_resp_valid), LW'(1'b1));
      chk("rerd_resp_data",  line_resp_data,       exp_line);
      step();

`ifdef MEM_TAG_CHECK_EN
      // ------------------------------------------------ tag mismatch drop
      for (int k = 0; k < 4; k++) beats[k] = {4{32'h7A90_0000 + 32'(k)}};
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      do_accept(1'b0, AW'(28'h0000999), '0);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      drive_beat(beats[0], '0);
      chk("tag_err_clear", LW'(tag_err), '0);
      drive_beat({4{32'hBAD0_BAD0}}, TW'(5));
      chk("tag_err_set",   LW'(tag_err), LW'(1'b1));
      for (int k = 1; k < 4; k++) begin
         chk("tag_no_early", LW'(line_resp_valid), '0);
         drive_beat(beats[k], '0);
      end
      chk("tag_resp_valid", LW'(line_resp_valid), LW'(1'b1));
      chk("tag_resp_data",  line_resp_data,       exp_line);
      step();
      chk("tag_err_sticky", LW'(tag_err), LW'(1'b1));
`else
      chk("tag_err_off", LW'(tag_err), '0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
